// File: rtl/rr_or_arbiter.sv
// Round-robin arbiter with rotating priority pointer, max-hold preemption and registered request OR.
// Optional owner lock input enabled by defining RR_OR_ARBITER_LOCK_EN.
module rr_or_arbiter #(
   parameter int N        = 4,
   parameter int ID_W     = 2,
   parameter int MAX_HOLD = 8
) (
   input  logic            clk,
   input  logic            rst_n,
`ifdef RR_OR_ARBITER_LOCK_EN
   input  logic            lock,
`endif
   input  logic [N-1:0]    req,
   output logic [N-1:0]    gnt,
   output logic            gnt_valid,
   output logic [ID_W-1:0] gnt_id,
   output logic            any_req
);

   typedef enum logic [0:0] {IDLE = 1'b0, OWNED = 1'b1} state_t;

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t          state_r;
   logic [N-1:0]    gnt_r;
   logic            gnt_valid_r;
   logic [ID_W-1:0] gnt_id_r;
   logic            any_req_r;
   logic [ID_W-1:0] ptr_r;
   logic [7:0]      hold_r;

   logic            win_found_s;
   logic [ID_W-1:0] win_id_s;
   logic [ID_W-1:0] next_ptr_s;
   logic            owner_req_s;
   logic            others_s;
   logic            freeze_s;
   logic            preempt_s;
   logic            do_grant_s;
   logic            go_idle_s;
   logic            hold_inc_s;

`ifdef RR_OR_ARBITER_LOCK_EN
   assign freeze_s = lock;
`else
   assign freeze_s = 1'b0;
`endif

   assign owner_req_s = |(req & gnt_r);
   assign others_s    = |(req & ~gnt_r);
   assign preempt_s   = owner_req_s && others_s && (hold_r == HOLD_LAST) && !freeze_s;

   // First set request at or after ptr, wrapping N-1 -> 0.
   always_comb begin
      logic [ID_W-1:0] idx_v;
      idx_v       = '0;
      win_found_s = 1'b0;
      win_id_s    = '0;
      for (int i = 0; i < N; i++) begin
         idx_v = ID_W'((int'(ptr_r) + i) % N);
         if (!win_found_s && req[idx_v]) begin
            win_found_s = 1'b1;
            win_id_s    = idx_v;
         end else begin
            win_id_s    = win_id_s;
         end
      end
   end

   // Pointer value one past the winner, modulo N.
   always_comb begin
      if (win_id_s == ID_W'(N - 1)) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = win_id_s + ID_W'(1);
      end
   end

   // Per-state decision: new grant, drop to idle, or keep owner and advance hold counter.
   always_comb begin
      do_grant_s = 1'b0;
      go_idle_s  = 1'b0;
      hold_inc_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (win_found_s) begin
               do_grant_s = 1'b1;
            end else begin
               go_idle_s  = 1'b1;
            end
         end
         OWNED: begin
            if (!owner_req_s) begin
               if (win_found_s) begin
                  do_grant_s = 1'b1;
               end else begin
                  go_idle_s  = 1'b1;
               end
            end else if (preempt_s) begin
               do_grant_s = 1'b1;
            end else if (!freeze_s && (hold_r != HOLD_LAST)) begin
               hold_inc_s = 1'b1;
            end else begin
               hold_inc_s = 1'b0;
            end
         end
         default: begin
            go_idle_s = 1'b1;
         end
      endcase
   end

   // State, pointer, hold counter and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         gnt_r       <= '0;
         gnt_valid_r <= 1'b0;
         gnt_id_r    <= '0;
         any_req_r   <= 1'b0;
         ptr_r       <= '0;
         hold_r      <= 8'd0;
      end else begin
         any_req_r <= |req;
         if (do_grant_s) begin
            state_r     <= OWNED;
            gnt_r       <= {{(N-1){1'b0}}, 1'b1} << win_id_s;
            gnt_valid_r <= 1'b1;
            gnt_id_r    <= win_id_s;
            ptr_r       <= next_ptr_s;
            hold_r      <= 8'd0;
         end else if (go_idle_s) begin
            state_r     <= IDLE;
            gnt_r       <= '0;
            gnt_valid_r <= 1'b0;
            gnt_id_r    <= '0;
         end else if (hold_inc_s) begin
            hold_r      <= hold_r + 8'd1;
         end else begin
            hold_r      <= hold_r;
         end
      end
   end

   assign gnt       = gnt_r;
   assign gnt_valid = gnt_valid_r;
   assign gnt_id    = gnt_id_r;
   assign any_req   = any_req_r;

endmodule

// File: tb/tb_rr_or_arbiter.sv
// Scoreboard bench for rr_or_arbiter: a behavioural model queues expected outputs per cycle.
module tb_rr_or_arbiter;

   localparam int MAXH = 8;
`ifdef RR_OR_ARBITER_LOCK_EN
   localparam bit LOCK_ON = 1'b1;
`else
   localparam bit LOCK_ON = 1'b0;
`endif

   typedef struct {
      logic [3:0] gnt;
      logic       valid;
      logic [1:0] id;
      logic       any;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b1111;
   logic [3:0] gnt;
   logic       gnt_valid;
   logic [1:0] gnt_id;
   logic       any_req;
`ifdef RR_OR_ARBITER_LOCK_EN
   logic       lock = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   exp_t sb_q[$];

   // model state
   bit         m_owned = 1'b0;
   int         m_ptr = 0;
   int         m_hold = 0;
   int         m_id = 0;
   logic [3:0] m_gnt = 4'b0000;
   logic       m_any = 1'b0;

   rr_or_arbiter #(.N(4), .ID_W(2), .MAX_HOLD(MAXH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef RR_OR_ARBITER_LOCK_EN
      .lock      (lock),
`endif
      .req       (req),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id),
      .any_req   (any_req)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_owned = 1'b0; m_ptr = 0; m_hold = 0; m_id = 0; m_gnt = 4'b0000; m_any = 1'b0;
      sb_q.delete();
   endtask

   task automatic model_grant(input int w);
      m_owned = 1'b1; m_id = w; m_gnt = 4'b0001 << w; m_ptr = (w + 1) % 4; m_hold = 0;
   endtask

   // Drive inputs away from the edge, queue the model's expectation, advance one cycle.
   task automatic step(input logic [3:0] r, input logic lk);
      exp_t e;
      int   w;
      bit   found;
      bit   lk_eff;
      lk_eff = lk & LOCK_ON;
      req = r;
`ifdef RR_OR_ARBITER_LOCK_EN
      lock = lk;
`endif
      found = 1'b0;
      w = 0;
      for (int i = 0; i < 4; i++) begin
         if (!found && r[(m_ptr + i) % 4]) begin
            found = 1'b1;
            w = (m_ptr + i) % 4;
         end
      end
      if (!m_owned) begin
         if (found) model_grant(w);
      end else if (!r[m_id]) begin
         if (found) model_grant(w);
         else begin m_owned = 1'b0; m_gnt = 4'b0000; m_id = 0; end
      end else if (m_hold == MAXH - 1 && (r & ~m_gnt) != 4'b0000 && !lk_eff) begin
         model_grant(w);
      end else if (!lk_eff && m_hold < MAXH - 1) begin
         m_hold = m_hold + 1;
      end
      m_any = |r;
      e.gnt = m_gnt; e.valid = m_owned; e.id = 2'(m_id); e.any = m_any;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      #12;
      checks++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0 || any_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: gnt=%b valid=%b id=%0d any=%b required 0000 0 0 0", gnt, gnt_valid, gnt_id, any_req);
      end
      model_reset();
      rst_n = 1'b1;
      step(4'b1111, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (gnt !== e.gnt || gnt_valid !== e.valid || gnt_id !== e.id || any_req !== e.any || gnt !== 4'b0001) begin
         errors++;
         $display("FAIL reset_release: gnt=%b valid=%b id=%0d any=%b required %b %b %0d %b", gnt, gnt_valid, gnt_id, any_req, e.gnt, e.valid, e.id, e.any);
      end
   endtask

   task automatic test_rotation();
      logic [3:0] drops [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      logic [3:0] seq   [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         step(drops[i], 1'b0);
         e = sb_q.pop_front();
         checks++;
         if (gnt !== e.gnt || gnt_valid !== e.valid || gnt_id !== e.id || any_req !== e.any || gnt !== seq[i]) begin
            errors++;
            $display("FAIL rotation[%0d]: gnt=%b valid=%b id=%0d any=%b required %b %b %0d %b", i, gnt, gnt_valid, gnt_id, any_req, seq[i], e.valid, e.id, e.any);
         end
      end
      for (int i = 0; i < 2; i++) begin
         step(4'b0000, 1'b0);
         e = sb_q.pop_front();
         checks++;
         if (gnt !== e.gnt || gnt_valid !== e.valid || gnt_id !== e.id || any_req !== e.any) begin
            errors++;
            $display("FAIL to_idle[%0d]: gnt=%b valid=%b id=%0d any=%b required %b %b %0d %b", i, gnt, gnt_valid, gnt_id, any_req, e.gnt, e.valid, e.id, e.any);
         end
      end
   endtask

   task automatic test_preempt();
      exp_t e;
      int   held = 0;
      bit   seen = 1'b0;
      for (int i = 0; i < 14 && !seen; i++) begin
         step((i < 2) ? 4'b0001 : 4'b0101, 1'b0);
         e = sb_q.pop_front();
         checks++;
         if (gnt !== e.gnt || gnt_valid !== e.valid || gnt_id !== e.id || any_req !== e.any) begin
            errors++;
            $display("FAIL preempt_cycle[%0d]: gnt=%b valid=%b id=%0d any=%b required %b %b %0d %b", i, gnt, gnt_valid, gnt_id, any_req, e.gnt, e.valid, e.id, e.any);
         end
         if (gnt === 4'b0001) held++;
         if (gnt === 4'b0100) seen = 1'b1;
      end
      checks++;
      if (!seen || held != MAXH || gnt_id !== 2'd2) begin
         errors++;
         $display("FAIL preempt_hold: held=%0d seen=%0d id=%0d required held=%0d seen=1 id=2", held, seen, gnt_id, MAXH);
      end
      step(4'b0000, 1'b0);
      e = sb_q.pop_front();
   endtask

   task automatic test_lone();
      exp_t e;
      int   bad = 0;
      for (int i = 0; i < 50; i++) begin
         step(4'b0010, 1'b0);
         e = sb_q.pop_front();
         checks++;
         if (gnt !== e.gnt || gnt_valid !== e.valid || gnt_id !== e.id || any_req !== e.any || gnt !== 4'b0010) begin
            errors++;
            bad++;
            if (bad < 4) $display("FAIL lone[%0d]: gnt=%b valid=%b id=%0d any=%b required 0010 1 1 1", i, gnt, gnt_valid, gnt_id, any_req);
         end
      end
      step(4'b0000, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== e.id || any_req !== e.any) begin
         errors++;
         $display("FAIL lone_drop: gnt=%b valid=%b id=%0d any=%b required 0000 0 0 0", gnt, gnt_valid, gnt_id, any_req);
      end
   endtask

   task automatic test_wrap();
      logic [3:0] stim [5] = '{4'b0100, 4'b0000, 4'b0101, 4'b1010, 4'b0000};
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         step(stim[i], 1'b0);
         e = sb_q.pop_front();
         checks++;
         if (gnt !== e.gnt || gnt_valid !== e.valid || gnt_id !== e.id || any_req !== e.any) begin
            errors++;
            $display("FAIL wrap[%0d]: gnt=%b valid=%b id=%0d any=%b required %b %b %0d %b", i, gnt, gnt_valid, gnt_id, any_req, e.gnt, e.valid, e.id, e.any);
         end
         if (i == 2 && gnt !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_target: gnt=%b required 0001", gnt);
         end
         if (i == 3 && gnt !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_ptr: gnt=%b required 0010", gnt);
         end
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      step(4'b0100, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (gnt !== e.gnt || gnt !== 4'b0100) begin
         errors++;
         $display("FAIL async_setup: gnt=%b required 0100", gnt);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0 || any_req !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: gnt=%b valid=%b id=%0d any=%b required 0000 0 0 0", gnt, gnt_valid, gnt_id, any_req);
      end
      model_reset();
      #1 rst_n = 1'b1;
      step(4'b1010, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (gnt !== e.gnt || gnt_valid !== e.valid || gnt_id !== e.id || any_req !== e.any || gnt !== 4'b0010) begin
         errors++;
         $display("FAIL async_ptr_cleared: gnt=%b valid=%b id=%0d any=%b required 0010 1 1 1", gnt, gnt_valid, gnt_id, any_req);
      end
   endtask

   task automatic test_lock();
      exp_t e;
      int   bad = 0;
      step(4'b0000, 1'b0);
      e = sb_q.pop_front();
      step(4'b0010, 1'b1);
      e = sb_q.pop_front();
      for (int i = 0; i < 3 * MAXH; i++) begin
         step(4'b1010, 1'b1);
         e = sb_q.pop_front();
         checks++;
         if (gnt !== e.gnt || gnt_valid !== e.valid || gnt_id !== e.id || any_req !== e.any || (LOCK_ON && gnt !== 4'b0010)) begin
            errors++;
            bad++;
            if (bad < 4) $display("FAIL lock_hold[%0d]: gnt=%b id=%0d required %b %0d", i, gnt, gnt_id, e.gnt, e.id);
         end
      end
      step(4'b1000, 1'b1);
      e = sb_q.pop_front();
      checks++;
      if (gnt !== e.gnt || gnt_valid !== e.valid || gnt_id !== e.id || gnt !== 4'b1000) begin
         errors++;
         $display("FAIL lock_release: gnt=%b id=%0d required 1000 3", gnt, gnt_id);
      end
      step(4'b0000, 1'b0);
      e = sb_q.pop_front();
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_preempt();
      test_lone();
      test_wrap();
      test_async_reset();
      test_lock();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_or_arbiter.md
Name: rr_or_arbiter

Overview:
- Round-robin arbiter that shares one single-output resource between N requesters; the resource is typically an OR-combined bus or a shared gate output.
- Produces a registered one-hot grant, the encoded owner ID, and a registered OR-reduction of all requests (`any_req`) for upstream wake-up logic.
- Enforces fairness with a rotating priority pointer and a maximum-hold timer that preempts long owners.

Parameters:
- N, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of gnt_id; must equal ceil(log2(N)), with 1 for N=2.
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps the grant while others wait; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester request level; bit i high means requester i wants the resource.
- gnt  output  N  registered one-hot grant; all zero when idle.
- gnt_valid  output  1  registered; high when any gnt bit is high.
- gnt_id  output  ID_W  registered index of the granted requester; 0 when idle.
- any_req  output  1  registered OR of all req bits, sampled each cycle.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: gnt=0, gnt_valid=0, gnt_id=0, any_req=0, priority pointer ptr=0, hold counter=0, state=IDLE. Reset asserted mid-grant drops the grant immediately, asynchronously.
- Timing:
  - All outputs are registered.
  - req is sampled at a rising edge and the decision appears on the outputs after that same edge, so latency is 1 cycle.
  - any_req equals the OR of req sampled at the previous edge.
- Search rule: choose the first set req bit starting at index ptr, wrapping N-1 -> 0.
  - On every new grant to index k: ptr <= (k+1) mod N, hold counter <= 0.
- States: IDLE and OWNED.
- IDLE:
  - If req != 0: grant the search-rule winner, go to OWNED.
  - Otherwise stay in IDLE with all outputs zero.
- OWNED (owner k):
  - req[k]=0 and other requests pending: grant the search-rule winner at the same edge. No idle gap; stay in OWNED.
  - req[k]=0 and no other requests: gnt <= 0, go to IDLE.
  - req[k]=1 and hold counter = MAX_HOLD-1 and another bit set: preempt k and grant the search-rule winner.
    - The winner is never k, because ptr already points past k.
  - req[k]=1, no preemption: keep the grant. The hold counter increments and saturates at MAX_HOLD-1.
    - If no other requester is pending, the owner keeps the grant indefinitely.
- Simultaneous requests: resolved purely by ptr; no fixed priority exists.
- The same requester cannot win twice in a row while another requester is pending at the decision edge.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_valid equals the OR of gnt.
  - gnt_id matches the set bit of gnt.
- X on req is not tolerated and need not be handled.

Optional Feature:
- Macro: RR_OR_ARBITER_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit).
  - While lock=1 is sampled with the owner's req still high, the hold counter is frozen and preemption is suppressed.
  - Release by deasserting the owner's req behaves as normal.
  - lock is ignored in IDLE.
- When undefined: the port is absent and the MAX_HOLD preemption always applies.

Test Plan:
- Reset: rst_n=0 with req=4'b1111 -> gnt=0, gnt_valid=0, gnt_id=0, any_req=0. Release reset -> after 1 edge gnt=4'b0001, gnt_id=0, any_req=1.
- Rotation: req=4'b1111 held; each owner drops req for 1 cycle after its grant -> gnt sequence 0001, 0010, 0100, 1000, 0001, with no idle cycles between owners.
- Preemption: MAX_HOLD=8; req[0]=1 held, req[2] raised 2 cycles after grant 0 -> gnt=0001 for exactly 8 cycles total, then gnt=0100, gnt_id=2.
- Lone owner: req=4'b0010 held for 50 cycles -> gnt=0010 throughout, no preemption. Drop req -> next edge gnt=0, gnt_valid=0.
- Wrap: ptr=3 (last grant to 2), req=4'b0101 -> grant goes to 0, not 2, and ptr becomes 1.
- Async reset mid-grant: assert rst_n=0 between edges while gnt=0100 -> gnt=0 immediately, before the next edge. Under RR_OR_ARBITER_LOCK_EN, a separate run with lock=1 and req[1],req[3] high -> owner 1 keeps the grant past MAX_HOLD until req[1] drops.
